// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse host-to-device transmitter.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    WAIT_ACK,
    WAIT_RELEASE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  // Default timing at a 50 MHz system clock.
  localparam int unsigned DEF_INHIBIT_CYCLES  = 6000;     // 120 us
  localparam int unsigned DEF_REQ_HOLD_CYCLES = 100;      // 2 us
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1000000;  // 20 ms

  // Frame after the start bit: 8 data bits, parity, stop.
  localparam int unsigned FRAME_BITS = 10;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 lines plus falling-edge detect on CLK.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_level,
  output logic data_level,
  output logic clk_fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  // Next values of the synchronizer chains.
  always_comb begin
    clk_meta_d  = clk_raw;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = data_raw;
    data_sync_d = data_meta_q;
  end

  // Synchronizer registers; reset to the idle (released, high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign clk_level  = clk_sync_q;
  assign data_level = data_sync_q;
  assign clk_fall   = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out a
// frame on device clock edges, then check the device line acknowledge.
module mouse_transmitter
  import mouse_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES  = DEF_INHIBIT_CYCLES,
  parameter int unsigned REQ_HOLD_CYCLES = DEF_REQ_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic [1:0] BYTE_ERROR_CODE
);

  localparam int unsigned MAX_CYC = max3(INHIBIT_CYCLES, REQ_HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic clk_level, data_level, clk_fall;

  ps2_line_sync u_sync (
    .clk       (CLK),
    .rst       (RESET),
    .clk_raw   (CLK_MOUSE_IN),
    .data_raw  (DATA_MOUSE_IN),
    .clk_level (clk_level),
    .data_level(data_level),
    .clk_fall  (clk_fall)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  clk_en_q, clk_en_d;
  logic                  data_en_q, data_en_d;
  logic                  busy_q, busy_d;
  logic                  sent_q, sent_d;
  logic [1:0]            err_q, err_d;

  logic       timeout_hit;
  logic       finish;
  logic [1:0] finish_code;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic; every path that ends a transfer
  // raises finish so the completion bookkeeping lives in one place below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    frame_d     = frame_q;
    bit_cnt_d   = bit_cnt_q;
    clk_en_d    = clk_en_q;
    data_en_d   = data_en_q;
    busy_d      = busy_q;
    sent_d      = 1'b0;
    err_d       = err_q;
    finish      = 1'b0;
    finish_code = ERR_OK;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_en_d  = 1'b0;
        data_en_d = 1'b0;
        busy_d    = 1'b0;
        if (SEND_BYTE) begin
          frame_d   = {1'b1, odd_parity(BYTE_TO_SEND), BYTE_TO_SEND};
          bit_cnt_d = '0;
          clk_en_d  = 1'b1;
          busy_d    = 1'b1;
          err_d     = ERR_OK;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_en_d = 1'b1;
          state_d   = REQ;
        end
      end

      REQ: begin
        if (cnt_q == CNT_W'(REQ_HOLD_CYCLES - 1)) begin
          cnt_d    = '0;
          clk_en_d = 1'b0;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = ERR_TIMEOUT;
        end else if (clk_fall) begin
          cnt_d     = '0;
          data_en_d = ~frame_q[0];
          frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = ERR_TIMEOUT;
        end else if (clk_fall) begin
          cnt_d = '0;
          if (!data_level) begin
            state_d = WAIT_RELEASE;
          end else begin
            finish      = 1'b1;
            finish_code = ERR_NOACK;
          end
        end
      end

      WAIT_RELEASE: begin
        if (timeout_hit) begin
          finish      = 1'b1;
          finish_code = ERR_TIMEOUT;
        end else if (clk_fall) begin
          cnt_d = '0;
        end else if (clk_level && data_level) begin
          finish      = 1'b1;
          finish_code = ERR_OK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (finish) begin
      state_d   = IDLE;
      cnt_d     = '0;
      clk_en_d  = 1'b0;
      data_en_d = 1'b0;
      busy_d    = 1'b0;
      sent_d    = 1'b1;
      err_d     = finish_code;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      clk_en_q  <= 1'b0;
      data_en_q <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      clk_en_q  <= clk_en_d;
      data_en_q <= data_en_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
    end
  end

  assign CLK_MOUSE_OUT_EN  = clk_en_q;
  assign DATA_MOUSE_OUT_EN = data_en_q;
  assign BUSY              = busy_q;
  assign BYTE_SENT         = sent_q;
  assign BYTE_ERROR_CODE   = err_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: a PS/2 device model clocks the frame out of
// the host, and a scoreboard of expected frames/codes is checked on completion.
module tb_mouse_transmitter;

  localparam int INH  = 60;
  localparam int REQH = 10;
  localparam int TO   = 2000;
  localparam int HP   = 20;   // device clock half-period in system cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] byte_in = '0;
  logic       clk_en, data_en, busy, sent;
  logic [1:0] code;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       bus_clk, bus_data;

  // Open-drain wired-AND of host and device pull-downs.
  assign bus_clk  = ~(clk_en | dev_clk_low);
  assign bus_data = ~(data_en | dev_data_low);

  mouse_transmitter #(
    .INHIBIT_CYCLES (INH),
    .REQ_HOLD_CYCLES(REQH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK              (clk),
    .RESET            (rst),
    .CLK_MOUSE_IN     (bus_clk),
    .DATA_MOUSE_IN    (bus_data),
    .CLK_MOUSE_OUT_EN (clk_en),
    .DATA_MOUSE_OUT_EN(data_en),
    .SEND_BYTE        (send),
    .BYTE_TO_SEND     (byte_in),
    .BUSY             (busy),
    .BYTE_SENT        (sent),
    .BYTE_ERROR_CODE  (code)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Completion monitor: records pulses so short ones are never missed.
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         wide_cnt = 0;
  logic [1:0] done_code = '0;
  logic       prev_sent = 1'b0;
  always @(negedge clk) begin
    prev_sent <= sent;
    if (sent) begin
      done_cnt  <= done_cnt + 1;
      done_code <= code;
      done_cyc  <= cyc;
      if (prev_sent) wide_cnt <= wide_cnt + 1;
    end
  end

  typedef struct {
    logic [9:0] frame;
    logic [1:0] code;
    bit         chk_frame;
  } exp_t;
  exp_t sb[$];

  logic [9:0] cap;
  int         last_fall_cyc = 0;

  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    par = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  // Checks the host inhibit/request window starting at the current cycle.
  task automatic check_window();
    int n, dn, first;
    n = 0; dn = 0; first = -1;
    while (clk_en === 1'b1 && n < INH + REQH + 50) begin
      if (data_en === 1'b1) begin
        if (first < 0) first = n;
        dn++;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != INH + REQH) begin
      errors++; $display("FAIL clk_low_len: got %0d want %0d", n, INH + REQH);
    end
    checks++;
    if (first != INH || dn != REQH) begin
      errors++; $display("FAIL data_low_window: start %0d len %0d want start %0d len %0d", first, dn, INH, REQH);
    end
    checks++;
    if (data_en !== 1'b1) begin
      errors++; $display("FAIL start_bit_held: data_en %b want 1", data_en);
    end
  endtask

  task automatic start_send(input logic [7:0] b, input logic [1:0] c, input bit chkf,
                            input bit hold);
    exp_t e;
    @(negedge clk);
    send = 1'b1;
    byte_in = b;
    e.frame = exp_frame(b); e.code = c; e.chk_frame = chkf;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) send = 1'b0;
    checks++;
    if (busy !== 1'b1 || clk_en !== 1'b1) begin
      errors++; $display("FAIL accept: busy %b clk_en %b want 1 1", busy, clk_en);
    end
    check_window();
  endtask

  // Device model: n falling edges; edge 11 carries the ack when ack=1.
  task automatic device_run(input int n, input bit ack, input int inject);
    cap = '0;
    for (int k = 1; k <= n; k++) begin
      if (k == 11) begin
        repeat (HP / 2) @(negedge clk);
        dev_data_low = ack;
        repeat (HP / 2) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fall_cyc = cyc;
      for (int i = 0; i < HP; i++) begin
        @(negedge clk);
        if (k == inject && i == 0) begin send = 1'b1; byte_in = 8'hAA; end
        else if (k == inject && i == 1) send = 1'b0;
      end
      if (k <= 10) cap[k-1] = bus_data;
      dev_clk_low = 1'b0;
    end
    if (n == 11) begin
      repeat (HP / 2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic finish_check(input int base, input bit restart);
    int w;
    exp_t e;
    w = 0;
    while (done_cnt == base && w < TO + 500) begin @(negedge clk); w++; end
    checks++;
    if (done_cnt == base) begin
      errors++; $display("FAIL done_wait: no BYTE_SENT within %0d cycles", TO + 500);
    end else if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard: BYTE_SENT with no expectation");
    end else begin
      e = sb.pop_front();
      checks++;
      if (done_code !== e.code) begin
        errors++; $display("FAIL err_code: got %b want %b", done_code, e.code);
      end
      if (e.chk_frame) begin
        checks++;
        if (cap !== e.frame) begin
          errors++; $display("FAIL frame: got %b want %b", cap, e.frame);
        end
      end
      checks++;
      if (restart) begin
        if (busy !== 1'b1 || clk_en !== 1'b1) begin
          errors++; $display("FAIL restart: busy %b clk_en %b want 1 1", busy, clk_en);
        end
      end else begin
        if (busy !== 1'b0 || clk_en !== 1'b0 || data_en !== 1'b0 || code !== e.code) begin
          errors++; $display("FAIL after_done: busy %b clk_en %b data_en %b code %b want 0 0 0 %b",
                             busy, clk_en, data_en, code, e.code);
        end
      end
      checks++;
      if (wide_cnt != 0) begin
        errors++; $display("FAIL sent_width: %0d wide pulses want 0", wide_cnt);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (clk_en !== 1'b0 || data_en !== 1'b0 || busy !== 1'b0 || sent !== 1'b0 || code !== 2'b00) begin
      errors++; $display("FAIL reset_state: %b%b%b%b %b want 0000 00", clk_en, data_en, busy, sent, code);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_send_ok(input logic [7:0] b);
    int base;
    base = done_cnt;
    start_send(b, 2'b00, 1'b1, 1'b0);
    device_run(11, 1'b1, 0);
    finish_check(base, 1'b0);
  endtask

  task automatic test_noack();
    int base;
    base = done_cnt;
    start_send(8'h5A, 2'b10, 1'b1, 1'b0);
    device_run(11, 1'b0, 0);
    finish_check(base, 1'b0);
  endtask

  task automatic test_timeout();
    int base, el;
    base = done_cnt;
    start_send(8'hF4, 2'b01, 1'b0, 1'b0);
    device_run(4, 1'b0, 0);
    finish_check(base, 1'b0);
    el = done_cyc - last_fall_cyc;
    checks++;
    if (el < TO || el > TO + 8) begin
      errors++; $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", el, TO, TO + 8);
    end
  endtask

  task automatic test_held_send();
    int base;
    exp_t e;
    base = done_cnt;
    start_send(8'h00, 2'b00, 1'b1, 1'b1);
    byte_in = 8'h3C;
    e.frame = exp_frame(8'h3C); e.code = 2'b00; e.chk_frame = 1'b1;
    sb.push_back(e);
    device_run(11, 1'b1, 0);
    finish_check(base, 1'b1);
    send = 1'b0;
    check_window();
    base = done_cnt;
    device_run(11, 1'b1, 0);
    finish_check(base, 1'b0);
  endtask

  task automatic test_ignore_busy();
    int base;
    base = done_cnt;
    start_send(8'hC3, 2'b00, 1'b1, 1'b0);
    device_run(11, 1'b1, 5);
    finish_check(base, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || clk_en !== 1'b0 || done_cnt != base + 1) begin
      errors++; $display("FAIL ignore_busy: busy %b clk_en %b done %0d want 0 0 %0d",
                         busy, clk_en, done_cnt, base + 1);
    end
  endtask

  task automatic test_reset_mid_send();
    int base;
    base = done_cnt;
    start_send(8'h96, 2'b00, 1'b1, 1'b0);
    device_run(5, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (clk_en !== 1'b0 || data_en !== 1'b0 || busy !== 1'b0 || sent !== 1'b0 || code !== 2'b00) begin
      errors++; $display("FAIL reset_mid: %b%b%b%b %b want 0000 00", clk_en, data_en, busy, sent, code);
    end
    void'(sb.pop_front());
    repeat (TO + 100) @(negedge clk);
    checks++;
    if (done_cnt != base || busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_pulse: done %0d busy %b want %0d 0", done_cnt, busy, base);
    end
  endtask

  initial begin
    test_reset();
    test_send_ok(8'hF4);
    test_send_ok(8'hFF);
    test_noack();
    test_timeout();
    test_held_send();
    test_ignore_busy();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
